// File: rtl/gbc_mem_pkg.sv
// ---------------------------------------------------------------------------
// gbc_mem_pkg
//   Shared definitions for the video/work BRAM access path: address and data
//   widths, the 2-bit requester IDs used to tag in-flight reads, the command
//   record a winning requester places on the BRAM port, and the saturating
//   wait-counter update used for starvation promotion.
// ---------------------------------------------------------------------------
package gbc_mem_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int ID_W   = 2;
    localparam int WAIT_W = 8;   // wide enough for a promotion limit up to 255

    typedef logic [ID_W-1:0] req_id_t;

    localparam req_id_t ID_NONE = 2'd0;
    localparam req_id_t ID_PPU  = 2'd1;
    localparam req_id_t ID_DMA  = 2'd2;
    localparam req_id_t ID_CPU  = 2'd3;

    // One BRAM port access as presented by the arbitration winner.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bram_cmd_t;

    // Consecutive-loss counter: counts cycles spent requesting without a
    // grant, saturates at lim, and restarts whenever the requester is
    // granted or withdraws its request.
    function automatic logic [WAIT_W-1:0] wait_next(
        input logic              req,
        input logic              gnt,
        input logic [WAIT_W-1:0] cur,
        input logic [WAIT_W-1:0] lim
    );
        if (!req || gnt) begin
            return '0;
        end
        if (cur >= lim) begin
            return lim;
        end
        return cur + WAIT_W'(1);
    endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// ---------------------------------------------------------------------------
// arb_tag_pipe
//   DEPTH-deep shift register of requester IDs. The arbiter pushes the owner
//   of each granted read (or ID_NONE) every cycle; the ID emerging at the far
//   end lines up with the BRAM read data for that access. An asynchronous
//   reset clears every stage to ID_NONE, which drops any reads in flight.
//
// Ports
//   clk_i   in   1     clock
//   rst_i   in   1     asynchronous active-high reset
//   tag_i   in   2     owner of the access granted this cycle
//   tag_o   out  2     owner whose read data is on the BRAM output now
// ---------------------------------------------------------------------------
module arb_tag_pipe
    import gbc_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  req_id_t tag_i,
    output req_id_t tag_o
);

    req_id_t stage_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= ID_NONE;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//   Shares the A port of the 32 KiB video/work BRAM between the PPU fetch
//   unit, the DMA engine (OAM/HDMA) and the CPU bus. One access is granted
//   per cycle. Priority is fixed PPU > DMA > CPU, except that a DMA or CPU
//   requester that has lost MAX_WAIT consecutive cycles is promoted above
//   everyone (promoted DMA ahead of promoted CPU). Read owners are tagged and
//   delayed by RD_LAT so the BRAM output is steered back to the requester
//   that issued the read.
//
// Request handshake (all three requesters):
//   A requester raises <x>_req with addr/we/wdata and holds them stable until
//   it observes <x>_gnt high in the same cycle; that cycle is the access. One
//   access per grant. Dropping req before a grant is legal and abandons the
//   request. Read data comes back as a single-cycle <x>_rvalid RD_LAT cycles
//   after the grant; writes produce no rvalid.
//
// Ports
//   clka, rsta                 clock, asynchronous active-high reset
//   ppu_req/addr -> ppu_gnt    PPU read requests (read-only requester)
//   ppu_rvalid, ppu_rdata      PPU read return
//   dma_req/we/addr/wdata      DMA requests, dma_gnt acceptance
//   dma_rvalid, dma_rdata      DMA read return
//   cpu_req/we/addr/wdata      CPU requests, cpu_gnt acceptance
//   cpu_rvalid, cpu_rdata      CPU read return
//   ena, wea, addra, dina      BRAM A-port command
//   douta                      BRAM A-port read data
// ---------------------------------------------------------------------------
module bram_port_arbiter
    import gbc_mem_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 7
) (
    input  logic              clka,
    input  logic              rsta,

    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic              ppu_gnt,
    output logic              ppu_rvalid,
    output logic [DATA_W-1:0] ppu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] douta
);

    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

    // ------------------------------------------------------------------
    // Starvation counters
    // ------------------------------------------------------------------
    logic [WAIT_W-1:0] dma_wait_q, dma_wait_d;
    logic [WAIT_W-1:0] cpu_wait_q, cpu_wait_d;
    logic              dma_promo;
    logic              cpu_promo;

    assign dma_promo = dma_req && (dma_wait_q == WAIT_LIM);
    assign cpu_promo = cpu_req && (cpu_wait_q == WAIT_LIM);

    // ------------------------------------------------------------------
    // Priority select
    // ------------------------------------------------------------------
    req_id_t   win_id;
    bram_cmd_t win_cmd;

    // Nothing is granted while reset is held, even with requests pending,
    // so the BRAM port stays idle until the arbiter is released.
    always_comb begin
        win_id = ID_NONE;
        if (!rsta) begin
            if (dma_promo) begin
                win_id = ID_DMA;
            end else if (cpu_promo) begin
                win_id = ID_CPU;
            end else if (ppu_req) begin
                win_id = ID_PPU;
            end else if (dma_req) begin
                win_id = ID_DMA;
            end else if (cpu_req) begin
                win_id = ID_CPU;
            end
        end
    end

    always_comb begin
        win_cmd = '0;
        case (win_id)
            ID_PPU: begin
                win_cmd.we    = 1'b0;
                win_cmd.addr  = ppu_addr;
                win_cmd.wdata = '0;
            end
            ID_DMA: begin
                win_cmd.we    = dma_we;
                win_cmd.addr  = dma_addr;
                win_cmd.wdata = dma_wdata;
            end
            ID_CPU: begin
                win_cmd.we    = cpu_we;
                win_cmd.addr  = cpu_addr;
                win_cmd.wdata = cpu_wdata;
            end
            default: begin
                win_cmd = '0;
            end
        endcase
    end

    assign ppu_gnt = (win_id == ID_PPU);
    assign dma_gnt = (win_id == ID_DMA);
    assign cpu_gnt = (win_id == ID_CPU);

    assign ena   = (win_id != ID_NONE);
    assign wea   = win_cmd.we;
    assign addra = win_cmd.addr;
    assign dina  = win_cmd.wdata;

    // ------------------------------------------------------------------
    // Counter registers
    // ------------------------------------------------------------------
    assign dma_wait_d = wait_next(dma_req, dma_gnt, dma_wait_q, WAIT_LIM);
    assign cpu_wait_d = wait_next(cpu_req, cpu_gnt, cpu_wait_q, WAIT_LIM);

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            dma_wait_q <= '0;
            cpu_wait_q <= '0;
        end else begin
            dma_wait_q <= dma_wait_d;
            cpu_wait_q <= cpu_wait_d;
        end
    end

    // ------------------------------------------------------------------
    // Read return routing
    // ------------------------------------------------------------------
    // Only reads carry an owner into the pipe; writes and idle cycles push
    // ID_NONE so they never produce an rvalid.
    req_id_t rd_tag;
    req_id_t ret_tag;

    assign rd_tag = (ena && !win_cmd.we) ? win_id : ID_NONE;

    arb_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk_i (clka),
        .rst_i (rsta),
        .tag_i (rd_tag),
        .tag_o (ret_tag)
    );

    assign ppu_rvalid = (ret_tag == ID_PPU);
    assign dma_rvalid = (ret_tag == ID_DMA);
    assign cpu_rvalid = (ret_tag == ID_CPU);

    // Read data is zeroed when not valid so the idle and reset values are
    // deterministic rather than whatever the BRAM output happens to hold.
    assign ppu_rdata = ppu_rvalid ? douta : '0;
    assign dma_rdata = dma_rvalid ? douta : '0;
    assign cpu_rdata = cpu_rvalid ? douta : '0;

endmodule
